// File: rtl/link_ber_sequencer.sv
// Run controller for the PRBS7 receive-side link test: pulses the aligner reset, waits for
// frame lock, discards a settling interval, then accumulates bit/word errors over a window.
module link_ber_sequencer #(
    parameter int ALIGN_TIMEOUT = 4096,
    parameter int RST_CYCLES    = 4,
    parameter int SETTLE_WORDS  = 16,
    parameter int MAX_RETRY     = 3,
    parameter int WIN_W         = 32,
    parameter int ERR_W         = 40
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic [WIN_W-1:0] window_len,
    input  logic             aligned,
    input  logic [5:0]       word_err,
    output logic             aligner_reset,
    output logic             busy,
    output logic             done,
    output logic             fail,
    output logic [1:0]       fail_code,
    output logic [WIN_W-1:0] word_count,
    output logic [ERR_W-1:0] err_bit_count,
    output logic [WIN_W-1:0] err_word_count,
    output logic [3:0]       loss_count,
    output logic [2:0]       state
);
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ARST   = 3'd1,
        S_LOCK   = 3'd2,
        S_SETTLE = 3'd3,
        S_MEAS   = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        C_OK      = 2'b00,
        C_TIMEOUT = 2'b01,
        C_RETRY   = 2'b10,
        C_ABORT   = 2'b11
    } code_t;

    // One phase counter serves the reset pulse, the lock timeout and the settle interval.
    localparam int CNT_MAX = (ALIGN_TIMEOUT > SETTLE_WORDS)
                           ? ((ALIGN_TIMEOUT > RST_CYCLES) ? ALIGN_TIMEOUT : RST_CYCLES)
                           : ((SETTLE_WORDS > RST_CYCLES) ? SETTLE_WORDS : RST_CYCLES);
    localparam int CNT_W = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int RTY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] LOCK_LAST   = CNT_W'(ALIGN_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_WORDS - 1);
    localparam logic [RTY_W-1:0] RETRY_MAX   = RTY_W'(MAX_RETRY);

    state_t           cur;
    logic [CNT_W-1:0] phase_cnt;
    logic [RTY_W-1:0] retry;
    logic [WIN_W-1:0] window_q;

    logic [5:0]       err_clamped;
    logic [ERR_W:0]   bit_sum;
    logic [ERR_W-1:0] bits_next;
    logic [WIN_W-1:0] words_next;
    logic [WIN_W-1:0] err_words_next;
    logic             window_hit;

    // Saturating next values for the measurement counters.
    always_comb begin
        err_clamped    = (word_err > 6'd32) ? 6'd32 : word_err;
        bit_sum        = {1'b0, err_bit_count} + (ERR_W + 1)'(err_clamped);
        bits_next      = bit_sum[ERR_W] ? '1 : bit_sum[ERR_W-1:0];
        words_next     = (word_count == '1) ? word_count : word_count + WIN_W'(1);
        err_words_next = (word_err == 6'd0 || err_word_count == '1)
                       ? err_word_count : err_word_count + WIN_W'(1);
        window_hit     = (window_q != '0) && (word_count == window_q - WIN_W'(1));
    end

    assign state = cur;

    always_ff @(posedge clk) begin
        if (reset) begin
            cur            <= S_IDLE;
            aligner_reset  <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
            fail           <= 1'b0;
            fail_code      <= C_OK;
            word_count     <= '0;
            err_bit_count  <= '0;
            err_word_count <= '0;
            loss_count     <= '0;
            window_q       <= '0;
            retry          <= '0;
            phase_cnt      <= '0;
        end else begin
            case (cur)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        cur            <= S_ARST;
                        aligner_reset  <= 1'b1;
                        busy           <= 1'b1;
                        done           <= 1'b0;
                        fail           <= 1'b0;
                        fail_code      <= C_OK;
                        word_count     <= '0;
                        err_bit_count  <= '0;
                        err_word_count <= '0;
                        loss_count     <= '0;
                        window_q       <= window_len;
                        retry          <= '0;
                        phase_cnt      <= '0;
                    end
                end
                default: begin
                    if (abort) begin
                        cur           <= S_DONE;
                        aligner_reset <= 1'b0;
                        busy          <= 1'b0;
                        done          <= 1'b1;
                        fail          <= 1'b1;
                        fail_code     <= C_ABORT;
                    end else begin
                        case (cur)
                            S_ARST: begin
                                if (phase_cnt == RST_LAST) begin
                                    cur           <= S_LOCK;
                                    aligner_reset <= 1'b0;
                                    phase_cnt     <= '0;
                                end else begin
                                    phase_cnt <= phase_cnt + CNT_W'(1);
                                end
                            end
                            S_LOCK: begin
                                if (aligned) begin
                                    cur       <= S_SETTLE;
                                    phase_cnt <= '0;
                                end else if (phase_cnt == LOCK_LAST) begin
                                    cur       <= S_DONE;
                                    busy      <= 1'b0;
                                    done      <= 1'b1;
                                    fail      <= 1'b1;
                                    fail_code <= C_TIMEOUT;
                                end else begin
                                    phase_cnt <= phase_cnt + CNT_W'(1);
                                end
                            end
                            S_SETTLE, S_MEAS: begin
                                // Loss of lock outranks both settle completion and window completion.
                                if (!aligned) begin
                                    if (loss_count != 4'hF) begin
                                        loss_count <= loss_count + 4'd1;
                                    end
                                    if (retry < RETRY_MAX) begin
                                        retry         <= retry + RTY_W'(1);
                                        cur           <= S_ARST;
                                        aligner_reset <= 1'b1;
                                        phase_cnt     <= '0;
                                    end else begin
                                        cur       <= S_DONE;
                                        busy      <= 1'b0;
                                        done      <= 1'b1;
                                        fail      <= 1'b1;
                                        fail_code <= C_RETRY;
                                    end
                                end else if (cur == S_SETTLE) begin
                                    if (phase_cnt == SETTLE_LAST) begin
                                        cur <= S_MEAS;
                                    end else begin
                                        phase_cnt <= phase_cnt + CNT_W'(1);
                                    end
                                end else begin
                                    word_count     <= words_next;
                                    err_bit_count  <= bits_next;
                                    err_word_count <= err_words_next;
                                    if (window_hit) begin
                                        cur       <= S_DONE;
                                        busy      <= 1'b0;
                                        done      <= 1'b1;
                                        fail      <= 1'b0;
                                        fail_code <= C_OK;
                                    end
                                end
                            end
                            default: begin
                                cur           <= S_IDLE;
                                busy          <= 1'b0;
                                aligner_reset <= 1'b0;
                            end
                        endcase
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_link_ber_sequencer.sv
// Bench for link_ber_sequencer: scenario tasks drive a scripted aligner/error source and
// compare the DUT against a word-list model of what each run should have counted.
module tb_link_ber_sequencer;
    localparam int ALIGN_TIMEOUT = 4096;
    localparam int RST_CYCLES    = 4;
    localparam int SETTLE_WORDS  = 16;
    localparam int MAX_RETRY     = 3;
    localparam int WIN_W         = 32;
    localparam int ERR_W         = 40;
    localparam int CW            = 2 * WIN_W + ERR_W + 4;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_ARST   = 3'd1;
    localparam logic [2:0] S_LOCK   = 3'd2;
    localparam logic [2:0] S_SETTLE = 3'd3;
    localparam logic [2:0] S_MEAS   = 3'd4;
    localparam logic [2:0] S_DONE   = 3'd5;

    logic             clk = 1'b0;
    logic             reset, start, abort, aligned;
    logic [WIN_W-1:0] window_len;
    logic [5:0]       word_err;
    logic             aligner_reset, busy, done, fail;
    logic [1:0]       fail_code;
    logic [WIN_W-1:0] word_count, err_word_count;
    logic [ERR_W-1:0] err_bit_count;
    logic [3:0]       loss_count;
    logic [2:0]       state;

    int total = 0;
    int bad   = 0;

    // Clamped error value of every word the current run should have counted, plus lock losses.
    logic [5:0] exp_q[$];
    int         exp_loss;

    always #5 clk = ~clk;

    link_ber_sequencer #(
        .ALIGN_TIMEOUT(ALIGN_TIMEOUT), .RST_CYCLES(RST_CYCLES), .SETTLE_WORDS(SETTLE_WORDS),
        .MAX_RETRY(MAX_RETRY), .WIN_W(WIN_W), .ERR_W(ERR_W)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort), .window_len(window_len),
        .aligned(aligned), .word_err(word_err), .aligner_reset(aligner_reset), .busy(busy),
        .done(done), .fail(fail), .fail_code(fail_code), .word_count(word_count),
        .err_bit_count(err_bit_count), .err_word_count(err_word_count),
        .loss_count(loss_count), .state(state)
    );

    function automatic logic [CW-1:0] model_counts();
        longint unsigned bits = 0;
        int unsigned     nz   = 0;
        foreach (exp_q[i]) begin
            bits += longint'(exp_q[i]);
            if (exp_q[i] != 6'd0) nz++;
        end
        return {WIN_W'(exp_q.size()), ERR_W'(bits), WIN_W'(nz), 4'(exp_loss)};
    endfunction

    function automatic logic [5:0] rand_err();
        if ($urandom_range(0, 1) == 0) return 6'd0;
        return 6'($urandom_range(1, 63));
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cyc(input logic al);
        aligned  = al;
        word_err = rand_err();
        tick();
    endtask

    task automatic do_start(input logic [WIN_W-1:0] w);
        window_len = w;
        start      = 1'b1;
        aligned    = 1'b0;
        word_err   = rand_err();
        tick();
        start      = 1'b0;
        window_len = WIN_W'($urandom);
        exp_q.delete();
        exp_loss = 0;
    endtask

    // Returns how many observed cycles had aligner_reset high, including one cycle past the pulse.
    task automatic arst_phase(output int hi);
        hi = 0;
        for (int i = 0; i < RST_CYCLES; i++) begin
            if (aligner_reset === 1'b1) hi++;
            cyc(1'b0);
        end
        if (aligner_reset === 1'b1) hi++;
    endtask

    task automatic lock_phase(input int a);
        repeat (a - 1) cyc(1'b0);
        cyc(1'b1);
    endtask

    task automatic settle(input int n);
        repeat (n) cyc(1'b1);
    endtask

    task automatic meas_e(input logic [5:0] e);
        aligned  = 1'b1;
        word_err = e;
        tick();
        exp_q.push_back((e > 6'd32) ? 6'd32 : e);
    endtask

    task automatic meas_n(input int n);
        repeat (n) meas_e(rand_err());
    endtask

    task automatic loss_cycle();
        cyc(1'b0);
        exp_loss++;
    endtask

    task automatic abort_cycle();
        abort    = 1'b1;
        aligned  = 1'b0;
        word_err = 6'd5;
        tick();
        abort    = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; abort = 1'b0; aligned = 1'b0;
        window_len = '0; word_err = '0;
        repeat (3) tick();
        total++;
        if ({state, aligner_reset, busy, done, fail, fail_code} !== 9'h000) begin
            bad++; $display("FAIL reset_status got=%h want=000", {state, aligner_reset, busy, done, fail, fail_code});
        end
        total++;
        if ({word_count, err_bit_count, err_word_count, loss_count} !== '0) begin
            bad++; $display("FAIL reset_counts got=%h want=0", {word_count, err_bit_count, err_word_count, loss_count});
        end
        reset = 1'b0;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        total++;
        if ({state, busy, done, fail} !== {S_IDLE, 3'b000}) begin
            bad++; $display("FAIL idle_abort got=%h want=%h", {state, busy, done, fail}, {S_IDLE, 3'b000});
        end
    endtask

    task automatic test_normal();
        int hi;
        do_start(WIN_W'(100));
        total++;
        if ({state, aligner_reset, busy, done} !== {S_ARST, 3'b110}) begin
            bad++; $display("FAIL normal_arst got=%h want=%h", {state, aligner_reset, busy, done}, {S_ARST, 3'b110});
        end
        arst_phase(hi);
        total++;
        if (hi !== RST_CYCLES) begin
            bad++; $display("FAIL normal_pulse got=%0d want=%0d", hi, RST_CYCLES);
        end
        lock_phase(10);
        total++;
        if (state !== S_SETTLE) begin
            bad++; $display("FAIL normal_settle got=%0d want=%0d", state, S_SETTLE);
        end
        settle(SETTLE_WORDS);
        repeat (99) meas_e(6'd0);
        total++;
        if ({state, busy, done} !== {S_MEAS, 2'b10}) begin
            bad++; $display("FAIL normal_before_last got=%h want=%h", {state, busy, done}, {S_MEAS, 2'b10});
        end
        meas_e(6'd0);
        total++;
        if ({state, aligner_reset, busy, done, fail, fail_code} !== {S_DONE, 6'b001000}) begin
            bad++; $display("FAIL normal_done got=%h want=%h", {state, aligner_reset, busy, done, fail, fail_code}, {S_DONE, 6'b001000});
        end
        total++;
        if (word_count !== 32'd100 || err_bit_count !== '0) begin
            bad++; $display("FAIL normal_counts got=%0d/%0d want=100/0", word_count, err_bit_count);
        end
        repeat (3) cyc(1'($urandom_range(0, 1)));
        total++;
        if ({state, done, word_count} !== {S_DONE, 1'b1, 32'd100}) begin
            bad++; $display("FAIL normal_hold got=%h want=%h", {state, done, word_count}, {S_DONE, 1'b1, 32'd100});
        end
    endtask

    task automatic test_error_injection();
        int hi;
        do_start(WIN_W'(50));
        arst_phase(hi);
        lock_phase($urandom_range(1, 20));
        settle(SETTLE_WORDS);
        for (int i = 0; i < 50; i++) begin
            if (i == 3 || i == 7 || i == 11 || i == 20 || i == 30) meas_e(6'd3);
            else if (i == 40) meas_e(6'd40);
            else meas_e(6'd0);
        end
        total++;
        if ({err_bit_count, err_word_count, word_count} !== {40'd47, 32'd6, 32'd50}) begin
            bad++; $display("FAIL inject_counts got=%0d/%0d/%0d want=47/6/50", err_bit_count, err_word_count, word_count);
        end
        total++;
        if ({state, done, fail, fail_code} !== {S_DONE, 4'b1000}) begin
            bad++; $display("FAIL inject_status got=%h want=%h", {state, done, fail, fail_code}, {S_DONE, 4'b1000});
        end
    endtask

    task automatic test_random_runs();
        int hi, w, mode;
        for (int it = 0; it < 8; it++) begin
            w    = $urandom_range(1, 80);
            mode = $urandom_range(0, 2);
            do_start(WIN_W'(w));
            arst_phase(hi);
            lock_phase($urandom_range(1, 20));
            if (mode == 1) begin
                settle($urandom_range(0, SETTLE_WORDS - 1));
                loss_cycle();
            end else begin
                settle(SETTLE_WORDS);
                if (mode == 2) begin
                    meas_n($urandom_range(0, w - 1));
                    loss_cycle();
                end
            end
            if (mode != 0) begin
                total++;
                if ({state, aligner_reset, busy} !== {S_ARST, 2'b11}) begin
                    bad++; $display("FAIL rand%0d_relock got=%h want=%h", it, {state, aligner_reset, busy}, {S_ARST, 2'b11});
                end
                arst_phase(hi);
                total++;
                if (hi !== RST_CYCLES) begin
                    bad++; $display("FAIL rand%0d_pulse2 got=%0d want=%0d", it, hi, RST_CYCLES);
                end
                lock_phase($urandom_range(1, 20));
                settle(SETTLE_WORDS);
            end
            meas_n(w - exp_q.size() - 1);
            total++;
            if (done !== 1'b0) begin
                bad++; $display("FAIL rand%0d_early_done got=%b want=0", it, done);
            end
            meas_n(1);
            total++;
            if ({state, busy, done, fail, fail_code} !== {S_DONE, 5'b01000}) begin
                bad++; $display("FAIL rand%0d_status got=%h want=%h", it, {state, busy, done, fail, fail_code}, {S_DONE, 5'b01000});
            end
            total++;
            if ({word_count, err_bit_count, err_word_count, loss_count} !== model_counts()) begin
                bad++; $display("FAIL rand%0d_counts got=%h want=%h", it, {word_count, err_bit_count, err_word_count, loss_count}, model_counts());
            end
        end
    endtask

    task automatic test_retries();
        int hi;
        do_start(WIN_W'(500));
        arst_phase(hi); lock_phase(3); settle(SETTLE_WORDS); meas_n(5); loss_cycle();
        arst_phase(hi); lock_phase(7); settle(9); loss_cycle();
        arst_phase(hi); lock_phase(1); settle(SETTLE_WORDS); meas_n(3); loss_cycle();
        total++;
        if ({state, loss_count} !== {S_ARST, 4'd3}) begin
            bad++; $display("FAIL retry_third got=%h want=%h", {state, loss_count}, {S_ARST, 4'd3});
        end
        arst_phase(hi); lock_phase(2); settle(SETTLE_WORDS); meas_n(4); loss_cycle();
        total++;
        if ({state, busy, done, fail, fail_code} !== {S_DONE, 5'b01110}) begin
            bad++; $display("FAIL retry_status got=%h want=%h", {state, busy, done, fail, fail_code}, {S_DONE, 5'b01110});
        end
        total++;
        if ({word_count, err_bit_count, err_word_count, loss_count} !== model_counts() || loss_count !== 4'd4) begin
            bad++; $display("FAIL retry_counts got=%h want=%h", {word_count, err_bit_count, err_word_count, loss_count}, model_counts());
        end
    endtask

    task automatic test_align_timeout();
        int hi;
        do_start(WIN_W'(10));
        arst_phase(hi);
        repeat (ALIGN_TIMEOUT - 1) cyc(1'b0);
        total++;
        if ({state, done} !== {S_LOCK, 1'b0}) begin
            bad++; $display("FAIL timeout_early got=%h want=%h", {state, done}, {S_LOCK, 1'b0});
        end
        cyc(1'b0);
        total++;
        if ({state, busy, done, fail, fail_code} !== {S_DONE, 5'b01101}) begin
            bad++; $display("FAIL timeout_status got=%h want=%h", {state, busy, done, fail, fail_code}, {S_DONE, 5'b01101});
        end
        do_start(WIN_W'(5));
        total++;
        if ({state, busy, done, fail, fail_code} !== {S_ARST, 5'b10000}) begin
            bad++; $display("FAIL restart_clear got=%h want=%h", {state, busy, done, fail, fail_code}, {S_ARST, 5'b10000});
        end
        arst_phase(hi);
        lock_phase(ALIGN_TIMEOUT);
        total++;
        if (state !== S_SETTLE) begin
            bad++; $display("FAIL lock_last_cycle got=%0d want=%0d", state, S_SETTLE);
        end
        settle(SETTLE_WORDS);
        meas_n(5);
        total++;
        if ({state, fail, fail_code, word_count} !== {S_DONE, 3'b000, 32'd5}) begin
            bad++; $display("FAIL lock_last_run got=%h want=%h", {state, fail, fail_code, word_count}, {S_DONE, 3'b000, 32'd5});
        end
    endtask

    task automatic test_back_to_back();
        int hi;
        do_start(WIN_W'(1));
        arst_phase(hi); lock_phase(1); settle(SETTLE_WORDS); meas_n(1);
        total++;
        if ({state, done, word_count} !== {S_DONE, 1'b1, 32'd1}) begin
            bad++; $display("FAIL b2b_first got=%h want=%h", {state, done, word_count}, {S_DONE, 1'b1, 32'd1});
        end
        do_start(WIN_W'(2));
        total++;
        if ({word_count, err_bit_count, err_word_count, loss_count} !== '0) begin
            bad++; $display("FAIL b2b_cleared got=%h want=0", {word_count, err_bit_count, err_word_count, loss_count});
        end
        arst_phase(hi); lock_phase(2); settle(SETTLE_WORDS); meas_n(2);
        total++;
        if ({word_count, err_bit_count, err_word_count, loss_count} !== model_counts() || done !== 1'b1) begin
            bad++; $display("FAIL b2b_second got=%h want=%h", {word_count, err_bit_count, err_word_count, loss_count}, model_counts());
        end
    endtask

    task automatic test_abort_reset();
        int hi;
        do_start('0);
        arst_phase(hi); lock_phase(5); settle(SETTLE_WORDS); meas_n(30);
        window_len = WIN_W'(3);
        start      = 1'b1;
        meas_e(rand_err());
        start      = 1'b0;
        total++;
        if ({state, busy, done} !== {S_MEAS, 2'b10}) begin
            bad++; $display("FAIL busy_start got=%h want=%h", {state, busy, done}, {S_MEAS, 2'b10});
        end
        meas_n(10);
        abort_cycle();
        total++;
        if ({state, busy, done, fail, fail_code} !== {S_DONE, 5'b01111}) begin
            bad++; $display("FAIL abort_status got=%h want=%h", {state, busy, done, fail, fail_code}, {S_DONE, 5'b01111});
        end
        total++;
        if ({word_count, err_bit_count, err_word_count, loss_count} !== model_counts() || word_count !== 32'd41) begin
            bad++; $display("FAIL abort_counts got=%h want=%h", {word_count, err_bit_count, err_word_count, loss_count}, model_counts());
        end
        repeat (3) cyc(1'($urandom_range(0, 1)));
        total++;
        if ({word_count, err_bit_count, err_word_count, loss_count, state, fail_code} !== {model_counts(), S_DONE, 2'b11}) begin
            bad++; $display("FAIL abort_hold got=%h want=%h", {word_count, err_bit_count, err_word_count, loss_count}, model_counts());
        end
        do_start(WIN_W'(7));
        arst_phase(hi);
        repeat (3) cyc(1'b0);
        abort_cycle();
        total++;
        if ({state, fail, fail_code, word_count, loss_count} !== {S_DONE, 3'b111, 32'd0, 4'd0}) begin
            bad++; $display("FAIL abort_lock got=%h want=%h", {state, fail, fail_code, word_count, loss_count}, {S_DONE, 3'b111, 32'd0, 4'd0});
        end
        do_start('0);
        arst_phase(hi); lock_phase(4); settle(SETTLE_WORDS); meas_n(20);
        reset = 1'b1; start = 1'b1; abort = 1'b1; aligned = 1'b1;
        tick();
        reset = 1'b0; start = 1'b0; abort = 1'b0;
        total++;
        if ({state, aligner_reset, busy, done, fail, fail_code} !== 9'h000) begin
            bad++; $display("FAIL midrun_reset got=%h want=000", {state, aligner_reset, busy, done, fail, fail_code});
        end
        total++;
        if ({word_count, err_bit_count, err_word_count, loss_count} !== '0) begin
            bad++; $display("FAIL midrun_reset_counts got=%h want=0", {word_count, err_bit_count, err_word_count, loss_count});
        end
        cyc(1'b1);
        total++;
        if ({state, aligner_reset, busy} !== {S_IDLE, 2'b00}) begin
            bad++; $display("FAIL after_reset got=%h want=%h", {state, aligner_reset, busy}, {S_IDLE, 2'b00});
        end
    endtask

    initial begin
        test_reset();
        test_normal();
        test_error_injection();
        test_random_runs();
        test_retries();
        test_align_timeout();
        test_back_to_back();
        test_abort_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
